banked_reg_file: RTL and testbench



---
 rtl/regfile_pkg.sv | 33 +++
 rtl/reg_scoreboard.sv | 69 ++++++
 rtl/banked_reg_file.sv | 88 ++++++++
 tb/tb_banked_reg_file.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the banked register file.
// Addresses are {bank, index}; index 0 of every bank is hardwired zero.
package regfile_pkg;

  localparam int ZERO_INDEX = 0;

  // Widest address/data the read-request record can carry.
  localparam int REQ_SEL_W  = 16;
  localparam int REQ_DATA_W = 64;

  // One read port's request and response.
  typedef struct packed {
    logic [REQ_SEL_W-1:0]  sel;
    logic [REQ_DATA_W-1:0] data;
    logic                  busy;
  } rd_req_t;

  // Build a flat register address from a bank number and an index.
  function automatic int make_addr(input int bank, input int idx, input int idx_bits);
    return (bank << idx_bits) | idx;
  endfunction

  // Index field of a flat address.
  function automatic int addr_index(input int addr, input int idx_bits);
    return addr & ((1 << idx_bits) - 1);
  endfunction

  // Bank field of a flat address.
  function automatic int addr_bank(input int addr, input int idx_bits);
    return addr >> idx_bits;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, priority update
// (flush > issue > writeback > hold) and RAW/WAW issue-stall detection.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int IDX_BITS = 4,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_sel,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_dst,
  input  logic                 issue_has_dst,
  output logic                 issue_stall,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_sel,
  input  logic                 flush
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                dst_busy;
  logic                dst_nonzero;
  logic                issue_accept;
  logic [AW-1:0]       port_sel;

  assign dst_nonzero = addr_index(int'(issue_dst), IDX_BITS) != ZERO_INDEX;

  // Hazard detection: a register being written back this cycle is no longer busy.
  always_comb begin
    rd_busy  = '0;
    port_sel = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      port_sel   = rd_sel[k*AW +: AW];
      rd_busy[k] = busy_q[port_sel] && !(wr_en && (wr_sel == port_sel));
    end
    dst_busy     = busy_q[issue_dst] && !(wr_en && (wr_sel == issue_dst));
    issue_stall  = issue_valid && ((|rd_busy) || (issue_has_dst && dst_busy));
    issue_accept = issue_valid && !issue_stall;
  end

  // Busy next-state: a new pending write outranks a completing one on the same register.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (issue_accept && issue_has_dst && dst_nonzero && (issue_dst == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_en && (wr_sel == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  // Busy bit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/banked_reg_file.sv
// Multi-bank register file: data array, write-first read bypass, debug read,
// and a pending-write scoreboard that stalls issue on RAW/WAW hazards.
module banked_reg_file
  import regfile_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int NUM_BANKS     = 2,
  parameter int REGS_PER_BANK = 16,
  parameter int NUM_RD        = 2,
  parameter int AW            = $clog2(NUM_BANKS) + $clog2(REGS_PER_BANK)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*AW-1:0]    rd_sel,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_dst,
  input  logic                    issue_has_dst,
  output logic                    issue_stall,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_sel,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    flush,
  input  logic [AW-1:0]           dbg_sel,
  output logic [WIDTH-1:0]        dbg_data
);

  localparam int IDX_BITS = $clog2(REGS_PER_BANK);
  localparam int NUM_REGS = NUM_BANKS * REGS_PER_BANK;

  logic [WIDTH-1:0] mem_q [NUM_REGS];
  logic [WIDTH-1:0] mem_d [NUM_REGS];
  logic             wr_nonzero;

  assign wr_nonzero = addr_index(int'(wr_sel), IDX_BITS) != ZERO_INDEX;

  // Writeback into the array; index-0 slots are never written so they stay zero.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && wr_nonzero) begin
      mem_d[wr_sel] = wr_data;
    end
  end

  // Data array register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports with write-first bypass of the same-cycle writeback.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] sel;
    logic          bypass;
    assign sel    = rd_sel[k*AW +: AW];
    assign bypass = wr_en && (wr_sel == sel) && (addr_index(int'(sel), IDX_BITS) != ZERO_INDEX);
    assign rd_data[k*WIDTH +: WIDTH] = bypass ? wr_data : mem_q[sel];
  end

  // Debug port sees only committed state.
  assign dbg_data = mem_q[dbg_sel];

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .IDX_BITS (IDX_BITS),
    .AW       (AW)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .rd_sel        (rd_sel),
    .rd_busy       (rd_busy),
    .issue_valid   (issue_valid),
    .issue_dst     (issue_dst),
    .issue_has_dst (issue_has_dst),
    .issue_stall   (issue_stall),
    .wr_en         (wr_en),
    .wr_sel        (wr_sel),
    .flush         (flush)
  );

endmodule

// File: tb/tb_banked_reg_file.sv
// Bench for banked_reg_file: directed vector table, reset-mid-operation
// sequence, then randomized traffic against a behavioural model.
module tb_banked_reg_file;

  localparam int W   = 32;
  localparam int NB  = 2;
  localparam int RPB = 16;
  localparam int NR  = 2;
  localparam int AW  = 5;
  localparam int N   = NB * RPB;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*AW-1:0] rd_sel;
  logic [NR*W-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic            issue_valid;
  logic [AW-1:0]   issue_dst;
  logic            issue_has_dst;
  logic            issue_stall;
  logic            wr_en;
  logic [AW-1:0]   wr_sel;
  logic [W-1:0]    wr_data;
  logic            flush;
  logic [AW-1:0]   dbg_sel;
  logic [W-1:0]    dbg_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  banked_reg_file #(
    .WIDTH(W), .NUM_BANKS(NB), .REGS_PER_BANK(RPB), .NUM_RD(NR)
  ) dut (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_has_dst(issue_has_dst),
    .issue_stall(issue_stall), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .flush(flush), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  r0, r1;
    logic        we;
    logic [4:0]  ws;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  id;
    logic        ihd;
    logic        fl;
    logic [4:0]  dbg;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic        es;
    logic [31:0] edbg;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [4:0] r0, input logic [4:0] r1,
                     input logic we, input logic [4:0] ws, input logic [31:0] wd,
                     input logic iv, input logic [4:0] id, input logic ihd, input logic fl,
                     input logic [4:0] dbg,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb,
                     input logic es, input logic [31:0] edbg);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.we = we; v.ws = ws; v.wd = wd; v.iv = iv; v.id = id;
    v.ihd = ihd; v.fl = fl; v.dbg = dbg; v.e0 = e0; v.e1 = e1; v.eb = eb; v.es = es;
    v.edbg = edbg;
    vt.push_back(v);
  endtask

  task automatic idle_inputs();
    rd_sel = '0; issue_valid = 0; issue_dst = '0; issue_has_dst = 0;
    wr_en = 0; wr_sel = '0; wr_data = '0; flush = 0; dbg_sel = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_reg  [N];
  bit          m_busy [N];

  function automatic bit is_zero_idx(input int a);
    return (a % RPB) == 0;
  endfunction

  function automatic bit writing(input int a);
    return wr_en && (int'(wr_sel) == a);
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (is_zero_idx(a)) return 32'h0;
    if (writing(a)) return wr_data;
    return m_reg[a];
  endfunction

  function automatic bit m_pending(input int a);
    return m_busy[a] && !writing(a);
  endfunction

  function automatic bit m_stall();
    bit any_rd = 0;
    for (int k = 0; k < NR; k++) any_rd |= m_pending(int'(rd_sel[k*AW +: AW]));
    return issue_valid && (any_rd || (issue_has_dst && m_pending(int'(issue_dst))));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 0;
    end
  endtask

  // Apply the clock edge to the model using the inputs currently driven.
  task automatic m_edge();
    bit accept;
    if (rst) begin
      m_clear();
      return;
    end
    accept = issue_valid && !m_stall();
    if (wr_en && !is_zero_idx(int'(wr_sel))) m_reg[wr_sel] = wr_data;
    if (flush) begin
      for (int i = 0; i < N; i++) m_busy[i] = 0;
    end else begin
      if (wr_en) m_busy[wr_sel] = 0;
      if (accept && issue_has_dst && !is_zero_idx(int'(issue_dst))) m_busy[issue_dst] = 1;
    end
  endtask

  function automatic logic [4:0] pick_addr();
    logic [4:0] hot [6];
    hot[0] = 5'd1; hot[1] = 5'd2; hot[2] = 5'd3; hot[3] = 5'd17; hot[4] = 5'd16; hot[5] = 5'd0;
    if ($urandom_range(0, 1) == 0) return hot[$urandom_range(0, 5)];
    return 5'($urandom_range(0, N - 1));
  endfunction

  initial begin
    idle_inputs();
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;

    //   r0  r1  we ws  wd            iv id ihd fl dbg  e0            e1        eb     es edbg
    add(0,  1,  0, 0,  32'h0,        0, 0, 0, 0, 0,   32'h0,        32'h0,    2'b00, 0, 32'h0);
    add(17, 1,  0, 0,  32'h0,        0, 0, 0, 0, 17,  32'h0,        32'h0,    2'b00, 0, 32'h0);
    add(5,  21, 1, 5,  32'hDEADBEEF, 0, 0, 0, 0, 5,   32'hDEADBEEF, 32'h0,    2'b00, 0, 32'h0);
    add(5,  21, 0, 0,  32'h0,        0, 0, 0, 0, 5,   32'hDEADBEEF, 32'h0,    2'b00, 0, 32'hDEADBEEF);
    add(0,  0,  0, 0,  32'h0,        1, 3, 1, 0, 0,   32'h0,        32'h0,    2'b00, 0, 32'h0);
    add(0,  3,  0, 0,  32'h0,        1, 7, 0, 0, 0,   32'h0,        32'h0,    2'b10, 1, 32'h0);
    add(0,  3,  1, 3,  32'h7,        1, 7, 0, 0, 3,   32'h0,        32'h7,    2'b00, 0, 32'h0);
    add(0,  3,  0, 0,  32'h0,        0, 0, 0, 0, 3,   32'h0,        32'h7,    2'b00, 0, 32'h7);
    add(4,  0,  1, 4,  32'h44,       1, 4, 1, 0, 0,   32'h44,       32'h0,    2'b00, 0, 32'h0);
    add(0,  0,  0, 0,  32'h0,        1, 4, 1, 0, 0,   32'h0,        32'h0,    2'b00, 1, 32'h0);
    add(4,  0,  0, 0,  32'h0,        0, 0, 0, 0, 4,   32'h44,       32'h0,    2'b01, 0, 32'h44);
    add(0,  0,  0, 0,  32'h0,        1, 6, 1, 0, 0,   32'h0,        32'h0,    2'b00, 0, 32'h0);
    add(0,  0,  0, 0,  32'h0,        1, 9, 1, 0, 0,   32'h0,        32'h0,    2'b00, 0, 32'h0);
    add(6,  9,  0, 0,  32'h0,        0, 0, 0, 0, 0,   32'h0,        32'h0,    2'b11, 0, 32'h0);
    add(0,  0,  1, 8,  32'h88,       1, 10, 1, 1, 8,  32'h0,        32'h0,    2'b00, 0, 32'h0);
    add(6,  9,  0, 0,  32'h0,        0, 0, 0, 0, 8,   32'h0,        32'h0,    2'b00, 0, 32'h88);
    add(10, 4,  0, 0,  32'h0,        0, 0, 0, 0, 0,   32'h0,        32'h44,   2'b00, 0, 32'h0);
    add(0,  0,  1, 0,  32'hFFFFFFFF, 0, 0, 0, 0, 0,   32'h0,        32'h0,    2'b00, 0, 32'h0);
    add(16, 0,  1, 16, 32'hFFFFFFFF, 0, 0, 0, 0, 16,  32'h0,        32'h0,    2'b00, 0, 32'h0);
    add(16, 0,  0, 0,  32'h0,        1, 16, 1, 0, 16, 32'h0,        32'h0,    2'b00, 0, 32'h0);
    add(16, 16, 0, 0,  32'h0,        1, 16, 1, 0, 0,  32'h0,        32'h0,    2'b00, 0, 32'h0);
    add(5,  21, 0, 0,  32'h0,        0, 0, 0, 0, 0,   32'hDEADBEEF, 32'h0,    2'b00, 0, 32'h0);

    foreach (vt[i]) begin
      rd_sel = {vt[i].r1, vt[i].r0};
      wr_en = vt[i].we; wr_sel = vt[i].ws; wr_data = vt[i].wd;
      issue_valid = vt[i].iv; issue_dst = vt[i].id; issue_has_dst = vt[i].ihd;
      flush = vt[i].fl; dbg_sel = vt[i].dbg;
      @(negedge clk);
      chk("vec_rd0",   i, rd_data[31:0],  vt[i].e0);
      chk("vec_rd1",   i, rd_data[63:32], vt[i].e1);
      chk("vec_busy",  i, 32'(rd_busy),   32'(vt[i].eb));
      chk("vec_stall", i, 32'(issue_stall), 32'(vt[i].es));
      chk("vec_dbg",   i, dbg_data,       vt[i].edbg);
      next_cycle();
    end

    // Reset in the middle of pending work: rst must override flush/issue/write.
    idle_inputs();
    issue_valid = 1; issue_dst = 5'd12; issue_has_dst = 1;
    @(negedge clk);
    chk("rst_seq_issue_stall", 0, 32'(issue_stall), 32'd0);
    next_cycle();
    idle_inputs();
    wr_en = 1; wr_sel = 5'd13; wr_data = 32'h1313; rd_sel = {5'd0, 5'd12};
    @(negedge clk);
    chk("rst_seq_busy12", 0, 32'(rd_busy), 32'd1);
    next_cycle();
    idle_inputs();
    rst = 1; flush = 1; issue_valid = 1; issue_dst = 5'd14; issue_has_dst = 1;
    wr_en = 1; wr_sel = 5'd15; wr_data = 32'h5555;
    next_cycle();
    idle_inputs();
    rst = 0;
    rd_sel = {5'd13, 5'd12}; dbg_sel = 5'd5;
    issue_valid = 1; issue_dst = 5'd12; issue_has_dst = 1;
    @(negedge clk);
    chk("rst_seq_rd0",   0, rd_data[31:0],  32'h0);
    chk("rst_seq_rd1",   0, rd_data[63:32], 32'h0);
    chk("rst_seq_busy",  0, 32'(rd_busy),   32'd0);
    chk("rst_seq_stall", 0, 32'(issue_stall), 32'd0);
    chk("rst_seq_dbg",   0, dbg_data,       32'h0);
    issue_valid = 0;
    rd_sel = {5'd14, 5'd15};
    @(negedge clk);
    chk("rst_seq_rd15", 0, rd_data[31:0], 32'h0);
    chk("rst_seq_busy14", 0, 32'(rd_busy), 32'd0);

    // Randomized traffic against the model, starting from a fresh reset.
    idle_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
    m_clear();
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 149) == 0);
      rd_sel        = {pick_addr(), pick_addr()};
      issue_valid   = ($urandom_range(0, 2) != 0);
      issue_dst     = pick_addr();
      issue_has_dst = ($urandom_range(0, 4) != 0);
      wr_en         = ($urandom_range(0, 1) == 0);
      wr_sel        = pick_addr();
      wr_data       = $urandom;
      flush         = ($urandom_range(0, 24) == 0);
      dbg_sel       = pick_addr();
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        chk("rnd_rd_data", i, rd_data[k*W +: W], m_read(int'(rd_sel[k*AW +: AW])));
        chk("rnd_rd_busy", i, 32'(rd_busy[k]), 32'(m_pending(int'(rd_sel[k*AW +: AW]))));
      end
      chk("rnd_stall", i, 32'(issue_stall), 32'(m_stall()));
      chk("rnd_dbg",   i, dbg_data, m_reg[dbg_sel]);
      m_edge();
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
